imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 29 ++
 rtl/imem_loader_byte_packer.sv | 38 +++
 rtl/imem_loader.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
// The CSUM state exists only when LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

  localparam int LEN_W  = 16;
  localparam int CSUM_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5,
`ifdef LOADER_CHECKSUM_EN
    ERROR  = 3'd6,
    CSUM   = 3'd7
`else
    ERROR  = 3'd6
`endif
  } state_t;

  // Running checksum: XOR of every data byte in the image.
  function automatic logic [CSUM_W-1:0] csum_next(input logic [CSUM_W-1:0] acc,
                                                  input logic [7:0]        data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian 4-byte to 32-bit word assembler; complete flags the byte that
// finishes a word, and word carries that byte in bits 31:24 in the same cycle.
module byte_packer (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        in_en,
  input  logic [7:0]  in_byte,
  output logic [31:0] word,
  output logic        complete
);

  logic [1:0]  cnt_r;
  logic [23:0] low_r;

  assign complete = in_en && (cnt_r == 2'd3);
  assign word     = {in_byte, low_r};

  // Byte lane position and the three low bytes of the word in progress.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_r <= 2'd0;
      low_r <= 24'd0;
    end else if (clear) begin
      cnt_r <= 2'd0;
      low_r <= 24'd0;
    end else if (in_en) begin
      cnt_r <= cnt_r + 2'd1;
      case (cnt_r)
        2'd0:    low_r[7:0]   <= in_byte;
        2'd1:    low_r[15:8]  <= in_byte;
        2'd2:    low_r[23:16] <= in_byte;
        default: low_r        <= low_r;
      endcase
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream loader: length header, little-endian words written to imem,
// processor held in reset until the load completes. Option: LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int                ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  output logic              cpu_reset,
  output logic              done,
  output logic              err
);

  localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;
`ifdef LOADER_CHECKSUM_EN
  localparam state_t END_STATE = CSUM;
`else
  localparam state_t END_STATE = DONE;
`endif

  state_t             state_r, state_s;
  logic               in_ready_r, mem_wen_r, cpu_reset_r, done_r, err_r;
  logic [7:0]         len_lo_r;
  logic [LEN_W-1:0]   len_r, word_cnt_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [31:0]        data_r;

  logic               accept_s, pk_en_s, pk_complete_s;
  logic               cap_lo_s, cap_len_s, adv_s;
  logic [LEN_W-1:0]   len_s;
  logic [31:0]        pk_word_s;

  assign accept_s = in_valid && in_ready_r;
  assign len_s    = {in_data, len_lo_r};
  assign pk_en_s  = !start && (state_r == DATA) && accept_s;

  byte_packer u_packer (
    .clock    (clock),
    .reset    (reset),
    .clear    (start),
    .in_en    (pk_en_s),
    .in_byte  (in_data),
    .word     (pk_word_s),
    .complete (pk_complete_s)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [CSUM_W-1:0] csum_r;

  // Checksum accumulates every accepted data byte; start clears it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      csum_r <= '0;
    end else if (start) begin
      csum_r <= '0;
    end else if (pk_en_s) begin
      csum_r <= csum_next(csum_r, in_data);
    end
  end
`endif

  // Next-state and datapath strobes; start overrides every state.
  always_comb begin
    state_s   = state_r;
    cap_lo_s  = 1'b0;
    cap_len_s = 1'b0;
    adv_s     = 1'b0;
    if (start) begin
      state_s = LEN_LO;
    end else begin
      case (state_r)
        IDLE: state_s = IDLE;
        LEN_LO: begin
          if (accept_s) begin
            cap_lo_s = 1'b1;
            state_s  = LEN_HI;
          end else begin
            state_s = LEN_LO;
          end
        end
        LEN_HI: begin
          if (accept_s) begin
            cap_len_s = 1'b1;
            if (len_s == '0) begin
              state_s = END_STATE;
            end else if ({16'd0, len_s} > MAX_WORDS) begin
              state_s = ERROR;
            end else begin
              state_s = DATA;
            end
          end else begin
            state_s = LEN_HI;
          end
        end
        DATA: begin
          if (pk_complete_s) begin
            state_s = WRITE;
          end else begin
            state_s = DATA;
          end
        end
        WRITE: begin
          adv_s = 1'b1;
          if (word_cnt_r + LEN_W'(1) == len_r) begin
            state_s = END_STATE;
          end else begin
            state_s = DATA;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CSUM: begin
          if (accept_s) begin
            if (in_data == csum_r) begin
              state_s = DONE;
            end else begin
              state_s = ERROR;
            end
          end else begin
            state_s = CSUM;
          end
        end
`endif
        DONE:    state_s = DONE;
        ERROR:   state_s = ERROR;
        default: state_s = IDLE;
      endcase
    end
  end

  // State register plus output flags decoded from the next state, so each
  // flag is a flop that lines up exactly with the state it belongs to.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b0;
      mem_wen_r   <= 1'b0;
      cpu_reset_r <= 1'b1;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
`ifdef LOADER_CHECKSUM_EN
      in_ready_r  <= (state_s == LEN_LO) || (state_s == LEN_HI) ||
                     (state_s == DATA)   || (state_s == CSUM);
`else
      in_ready_r  <= (state_s == LEN_LO) || (state_s == LEN_HI) ||
                     (state_s == DATA);
`endif
      mem_wen_r   <= (state_s == WRITE);
      cpu_reset_r <= (state_s != DONE);
      done_r      <= (state_s == DONE);
      err_r       <= (state_s == ERROR);
    end
  end

  // Length capture, word counting, write address and write data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      len_lo_r   <= 8'd0;
      len_r      <= '0;
      word_cnt_r <= '0;
      addr_r     <= BASE_ADDR;
      data_r     <= 32'd0;
    end else if (start) begin
      len_lo_r   <= 8'd0;
      len_r      <= '0;
      word_cnt_r <= '0;
    end else begin
      if (cap_lo_s) begin
        len_lo_r <= in_data;
      end
      if (cap_len_s) begin
        len_r  <= len_s;
        addr_r <= BASE_ADDR;
      end else if (adv_s) begin
        addr_r     <= addr_r + ADDR_W'(1);
        word_cnt_r <= word_cnt_r + LEN_W'(1);
      end
      if (pk_complete_s) begin
        data_r <= pk_word_s;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign mem_wen   = mem_wen_r;
  assign mem_addr  = addr_r;
  assign mem_data  = data_r;
  assign cpu_reset = cpu_reset_r;
  assign done      = done_r;
  assign err       = err_r;

endmodule
